// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm sequencing controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_ARMED      = 3'd1,
    ST_RINGING    = 3'd2,
    ST_SNOOZE     = 3'd3,
    ST_WAIT_CLEAR = 3'd4
  } alarm_state_t;

  localparam int DEF_RING_SEC   = 60;
  localparam int DEF_SNOOZE_SEC = 300;
  localparam int DEF_MAX_SNOOZE = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Loadable, tick-enabled up/down seconds counter that saturates at 0 and MAXV.
module sec_timer #(
  parameter int WIDTH = 6,
  parameter int MAXV  = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_end
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAXV);

  // Load wins over counting so a state change always starts from a known value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick_en) begin
      if (dec) begin
        if (count != '0) count <= count - 1'b1;
      end else begin
        if (count != MAX_VAL) count <= count + 1'b1;
      end
    end
  end

  assign at_end = dec ? (count == '0) : (count == MAX_VAL);

endmodule

// File: rtl/alarm_seq_ctrl.sv
// Alarm sequencing FSM: gates buzz with ring timeout, snooze countdown and snooze limit.
module alarm_seq_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = DEF_RING_SEC,
  parameter int SNOOZE_SEC = DEF_SNOOZE_SEC,
  parameter int MAX_SNOOZE = DEF_MAX_SNOOZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick,
  input  logic                              alarm_on,
  input  logic                              match,
  input  logic                              snooze_btn,
  output logic                              buzz,
  output logic                              snoozing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_ct,
  output logic [2:0]                        state
);

  localparam int TMAX = max_int(RING_SEC, SNOOZE_SEC);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = $clog2(MAX_SNOOZE + 1);

  alarm_state_t cur_state, next_state;
  logic         btn_q;
  logic         press;
  logic         tmr_load, tmr_en, tmr_dec, tmr_at_end;
  logic [TW-1:0] tmr_load_val, tmr_count;
  logic         ct_clr, ct_inc;
  logic         buzz_d, snoozing_d;

  assign press = snooze_btn & ~btn_q;

  sec_timer #(
    .WIDTH (TW),
    .MAXV  (RING_SEC - 1)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick_en  (tmr_en),
    .dec      (tmr_dec),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count    (tmr_count),
    .at_end   (tmr_at_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= ST_OFF;
      btn_q     <= 1'b0;
      buzz      <= 1'b0;
      snoozing  <= 1'b0;
      snooze_ct <= '0;
    end else begin
      cur_state <= next_state;
      btn_q     <= snooze_btn;
      buzz      <= buzz_d;
      snoozing  <= snoozing_d;
      if (ct_clr)      snooze_ct <= '0;
      else if (ct_inc) snooze_ct <= snooze_ct + 1'b1;
    end
  end

  // Priority: switch off, then snooze press, then tick/timeout.
  always_comb begin
    next_state   = cur_state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    tmr_dec      = (cur_state == ST_SNOOZE);
    ct_clr       = 1'b0;
    ct_inc       = 1'b0;
    if (!alarm_on) begin
      next_state = ST_OFF;
    end else begin
      case (cur_state)
        ST_OFF: next_state = match ? ST_WAIT_CLEAR : ST_ARMED;
        ST_ARMED: begin
          if (match) begin
            next_state = ST_RINGING;
            tmr_load   = 1'b1;
            ct_clr     = 1'b1;
          end
        end
        ST_RINGING: begin
          if (press) begin
            if (snooze_ct < CW'(MAX_SNOOZE)) begin
              next_state   = ST_SNOOZE;
              tmr_load     = 1'b1;
              tmr_load_val = TW'(SNOOZE_SEC - 1);
              ct_inc       = 1'b1;
            end else begin
              next_state = ST_WAIT_CLEAR;
            end
          end else if (tick) begin
            if (tmr_at_end) next_state = ST_WAIT_CLEAR;
            else            tmr_en     = 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (tick) begin
            if (tmr_at_end) begin
              next_state = ST_RINGING;
              tmr_load   = 1'b1;
            end else begin
              tmr_en = 1'b1;
            end
          end
        end
        ST_WAIT_CLEAR: begin
          if (!match) begin
            next_state = ST_ARMED;
            ct_clr     = 1'b1;
          end
        end
        default: next_state = ST_OFF;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    buzz_d     = (next_state == ST_RINGING);
    snoozing_d = (next_state == ST_SNOOZE);
  end

  assign state = cur_state;

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// Directed self-checking bench for alarm_seq_ctrl with short ring/snooze timing.
module tb_alarm_seq_ctrl;

  localparam int RING_SEC   = 4;
  localparam int SNOOZE_SEC = 3;
  localparam int MAX_SNOOZE = 2;

  localparam int S_OFF = 0, S_ARMED = 1, S_RING = 2, S_SNOOZE = 3, S_WAIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       alarm_on = 1'b0;
  logic       match = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       buzz;
  logic       snoozing;
  logic [1:0] snooze_ct;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  alarm_seq_ctrl #(
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .alarm_on   (alarm_on),
    .match      (match),
    .snooze_btn (snooze_btn),
    .buzz       (buzz),
    .snoozing   (snoozing),
    .snooze_ct  (snooze_ct),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock cycle with the given inputs; returns 1ns after the edge.
  task automatic applyStimulus(input logic t, input logic a, input logic m, input logic b);
    tick       = t;
    alarm_on   = a;
    match      = m;
    snooze_btn = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    checkOutput("rst_state", state, S_OFF);
    checkOutput("rst_buzz", buzz, 0);
    checkOutput("rst_snoozing", snoozing, 0);
    checkOutput("rst_ct", snooze_ct, 0);
    rst = 1'b1;
    #5;

    applyStimulus(0, 1, 0, 0);
    checkOutput("s1_armed", state, S_ARMED);
    applyStimulus(0, 1, 1, 0);
    checkOutput("s1_ring_state", state, S_RING);
    checkOutput("s1_ring_buzz", buzz, 1);
    checkOutput("s1_ring_ct", snooze_ct, 0);

    applyStimulus(1, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("s2_still_ring", state, S_RING);
    applyStimulus(1, 1, 1, 0);
    checkOutput("s2_timeout_state", state, S_WAIT);
    checkOutput("s2_timeout_buzz", buzz, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("s2_rearm", state, S_ARMED);
    checkOutput("s2_rearm_ct", snooze_ct, 0);

    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("s3_snooze_state", state, S_SNOOZE);
    checkOutput("s3_snoozing", snoozing, 1);
    checkOutput("s3_buzz_off", buzz, 0);
    checkOutput("s3_ct", snooze_ct, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("s3_still_snooze", state, S_SNOOZE);
    applyStimulus(1, 1, 0, 0);
    checkOutput("s3_rering_state", state, S_RING);
    checkOutput("s3_rering_buzz", buzz, 1);
    checkOutput("s3_rering_snoozing", snoozing, 0);
    checkOutput("s3_rering_ct", snooze_ct, 1);

    // Button held across a full snooze and back into ringing: one press only.
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i >= 1 && i <= 3) ? 1'b1 : 1'b0, 1, 0, 1);
      if (i == 0) checkOutput("s4_press2_state", state, S_SNOOZE);
    end
    checkOutput("s4_hold_state", state, S_RING);
    checkOutput("s4_hold_ct", snooze_ct, 2);
    checkOutput("s4_hold_buzz", buzz, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("s4_limit_state", state, S_WAIT);
    checkOutput("s4_limit_buzz", buzz, 0);
    checkOutput("s4_limit_ct", snooze_ct, 2);
    applyStimulus(0, 1, 0, 0);
    checkOutput("s4_clear_state", state, S_ARMED);
    checkOutput("s4_clear_ct", snooze_ct, 0);

    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("s5_press_wins", state, S_SNOOZE);
    checkOutput("s5_press_ct", snooze_ct, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("s5_off_from_snooze", state, S_OFF);
    checkOutput("s5_off_snoozing", snoozing, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("s5_ring_again", buzz, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("s5_off_from_ring", state, S_OFF);
    checkOutput("s5_off_buzz", buzz, 0);

    applyStimulus(0, 1, 1, 0);
    checkOutput("s6_arm_in_match", state, S_WAIT);
    checkOutput("s6_arm_in_match_buzz", buzz, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("s6_wait_hold", state, S_WAIT);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("s6_pre_rst_snoozing", snoozing, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("s6_async_state", state, S_OFF);
    checkOutput("s6_async_snoozing", snoozing, 0);
    checkOutput("s6_async_buzz", buzz, 0);
    checkOutput("s6_async_ct", snooze_ct, 0);
    #10;
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_seq_ctrl.md
Name: alarm_seq_ctrl

Overview:
Alarm sequencing controller that sits between the alarm time comparator and the Buzz output of the alarm clock top level. It takes the comparator's time-match level, the 1/sec Pulse (as a tick enable), the Alarmon switch and a snooze button. It produces a gated buzz with ring timeout, snooze countdown and a snooze-count limit. It replaces the plain Alarmon AND-gate on Buzz.

Parameters:
RING_SEC, 60, ticks the alarm rings before auto-stop (timeout)
SNOOZE_SEC, 300, ticks of silence after a snooze press before re-ring
MAX_SNOOZE, 3, snoozes allowed per alarm event; a further press acts as stop

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
tick  input  1  one-clk-wide pulse, once per second
alarm_on  input  1  Alarmon switch level, already synchronous
match  input  1  level from comparator; 1 while clock time == alarm time (held a full minute)
snooze_btn  input  1  snooze button level, synchronous; rising edge detected internally
buzz  output  1  registered buzzer drive
snoozing  output  1  registered; 1 while in SNOOZE
snooze_ct  output  $clog2(MAX_SNOOZE+1)  snoozes used in the current event
state  output  3  current state encoding, for debug and display

Behaviour:
- Reset (rst=0, async): state=OFF, buzz=0, snoozing=0, snooze_ct=0, timer=0, button-edge register=0.
- States: OFF=0, ARMED=1, RINGING=2, SNOOZE=3, WAIT_CLEAR=4. All transitions happen on the clk edge. buzz and snoozing are registered and reflect the new state in the same cycle the state changes.
- Priority in every state: alarm_on=0 forces OFF next edge, then snooze_btn edge, then tick and timeout events.
- Snooze edge: press = snooze_btn=1 while the registered previous value=0. One press equals one event regardless of hold length.
- OFF: if alarm_on=1 and match=1, go to WAIT_CLEAR. Arming inside the matching minute does not ring.
- OFF: if alarm_on=1 and match=0, go to ARMED.
- ARMED: if match=1, go to RINGING with timer=0 and snooze_ct=0.
- RINGING: buzz=1.
  - Press with snooze_ct<MAX_SNOOZE: go to SNOOZE, timer=SNOOZE_SEC-1, snooze_ct+1.
  - Press with snooze_ct==MAX_SNOOZE: go to WAIT_CLEAR.
  - Otherwise each tick increments timer. A tick with timer==RING_SEC-1 goes to WAIT_CLEAR (timeout).
  - A press and the timeout tick in the same cycle: the press wins.
- SNOOZE: buzz=0, snoozing=1.
  - Each tick decrements timer.
  - A tick with timer==0 goes to RINGING with timer=0. snooze_ct is held.
  - Presses are ignored.
  - The state is independent of match, so a re-ring after the match minute has ended still occurs.
- WAIT_CLEAR: buzz=0. When match=0, go to ARMED and clear snooze_ct. snooze_ct holds its value until then.
- Timer width: $clog2(max(RING_SEC,SNOOZE_SEC)). The timer never wraps: increment stops at RING_SEC-1 and decrement stops at 0.
- tick present in a cycle with no state effect is simply consumed. No tick is buffered.
- A reset asserted mid-ring or mid-snooze clears everything immediately (async). Release is synchronous to clk.

Decomposition:
- Package alarm_pkg holds the state enum (typedef, 3-bit, values above) and the default parameter constants.
- One natural sub-module: sec_timer. It is a loadable tick-enabled counter with inc/dec mode, load value and a terminal flag, and it saturates at its end values.
- Edge detect and FSM stay in alarm_seq_ctrl.

Test Plan:
All scenarios use RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2.
1. Reset then alarm_on=1, match=0 -> state=ARMED. Raise match -> next edge RINGING, buzz=1, snooze_ct=0.
2. Ringing with no press, 4 ticks -> after 4th tick state=WAIT_CLEAR, buzz=0. Drop match -> ARMED, snooze_ct=0.
3. Ringing, press snooze -> SNOOZE, snoozing=1, snooze_ct=1. After 3 ticks -> RINGING, buzz=1 even with match=0.
4. Three press/re-ring cycles -> presses 1 and 2 give SNOOZE with snooze_ct=2. Press 3 gives WAIT_CLEAR, buzz=0. Holding snooze_btn high for 10 clk counts as one press.
5. Press and 4th ring tick in the same cycle -> SNOOZE, not WAIT_CLEAR. alarm_on=0 during RINGING or SNOOZE -> OFF next edge, buzz=0.
6. alarm_on rises while match=1 -> WAIT_CLEAR, no buzz. Async rst low mid-SNOOZE (between clk edges) -> outputs 0 immediately, state=OFF.
